// File: rtl/ds1302_target.sv
// ds1302_target
//   DS1302-compatible responder for the 3-wire CE/SCLK/IO bus. Decodes an
//   LSB-first command byte, serves one single-byte read or write per CE frame
//   against a clock register set (sec, min, hour, date, month, day, year,
//   control, trickle) and a RAM_BYTES-deep RAM, and keeps sec/min/hour running
//   in BCD from a 1 Hz tick while the CH bit (sec[7]) is clear.
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   ce, sclk      bus chip enable / serial clock (asynchronous, synchronized here)
//   io_in         bus data from the pad (asynchronous, synchronized here)
//   io_out, io_oe bus data to the pad and its output enable (tristate built above)
//   tick_1hz      one-clk pulse per second
//   time_sec      seconds register (bit7 = CH), BCD
//   time_min      minutes register, BCD
//   time_hour     hours register, 24h BCD (bit7 ignored)
//   frame_done    one-clk pulse when a byte transfer completes
//   frame_err     one-clk pulse on an invalid command or a CE drop mid-byte

module ds1302_target #(
    parameter int SYNC_STAGES = 2,
    parameter int RAM_BYTES   = 31
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       sclk,
    input  logic       io_in,
    output logic       io_out,
    output logic       io_oe,
    input  logic       tick_1hz,
    output logic [7:0] time_sec,
    output logic [7:0] time_min,
    output logic [7:0] time_hour,
    output logic       frame_done,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_WCOMMIT,
        S_RDATA,
        S_DONE
    } state_t;

    localparam int RAM_AW = (RAM_BYTES > 1) ? $clog2(RAM_BYTES) : 1;

    localparam logic [4:0] ADDR_SEC     = 5'd0;
    localparam logic [4:0] ADDR_MIN     = 5'd1;
    localparam logic [4:0] ADDR_HOUR    = 5'd2;
    localparam logic [4:0] ADDR_DATE    = 5'd3;
    localparam logic [4:0] ADDR_MONTH   = 5'd4;
    localparam logic [4:0] ADDR_DAY     = 5'd5;
    localparam logic [4:0] ADDR_YEAR    = 5'd6;
    localparam logic [4:0] ADDR_CTRL    = 5'd7;
    localparam logic [4:0] ADDR_TRICKLE = 5'd8;

    // ------------------------------------------------------------------
    // Input synchronizers and SCLK edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] ce_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] io_sync;
    logic                   sclk_prev;
    logic                   ce_s;
    logic                   sclk_s;
    logic                   io_s;
    logic                   sclk_rise;
    logic                   sclk_fall;

    // NOTE: all sequential state is written with non-blocking assignments so
    // every flop in the design samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_sync   <= '0;
            sclk_sync <= '0;
            io_sync   <= '0;
            sclk_prev <= 1'b0;
        end else begin
            ce_sync   <= {ce_sync[SYNC_STAGES-2:0], ce};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            io_sync   <= {io_sync[SYNC_STAGES-2:0], io_in};
            sclk_prev <= sclk_s;
        end
    end

    assign ce_s      = ce_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign io_s      = io_sync[SYNC_STAGES-1];
    assign sclk_rise = ce_s & sclk_s & ~sclk_prev;
    assign sclk_fall = ce_s & ~sclk_s & sclk_prev;

    // ------------------------------------------------------------------
    // Register file and RAM
    // ------------------------------------------------------------------
    logic [7:0] sec_q;
    logic [7:0] min_q;
    logic [7:0] hour_q;
    logic [7:0] date_q;
    logic [7:0] month_q;
    logic [7:0] day_q;
    logic [7:0] year_q;
    logic [7:0] ctrl_q;
    logic [7:0] trickle_q;
    logic [7:0] ram [RAM_BYTES];

    // ------------------------------------------------------------------
    // Transfer FSM state
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [4:0] cmd_addr_q, cmd_addr_d;
    logic       cmd_ram_q, cmd_ram_d;
    logic       io_out_d;
    logic       io_oe_d;
    logic       done_d;
    logic       err_d;

    // Byte as it will look once the current io bit is shifted in (LSB first,
    // so new bits enter at the MSB and the first bit ends up in bit 0).
    logic [7:0] shift_in;
    logic [4:0] in_addr;
    logic       in_ram;
    logic [7:0] rd_byte;

    assign shift_in = {io_s, shreg_q[7:1]};
    assign in_addr  = shift_in[5:1];
    assign in_ram   = shift_in[6];

    // Read data is looked up from the command byte being completed, so it is
    // captured into the shift register on the same edge as the 8th command bit.
    always_comb begin
        rd_byte = 8'h00;
        if (in_ram) begin
            if (int'(in_addr) < RAM_BYTES) begin
                rd_byte = ram[in_addr[RAM_AW-1:0]];
            end
        end else begin
            case (in_addr)
                ADDR_SEC:     rd_byte = sec_q;
                ADDR_MIN:     rd_byte = min_q;
                ADDR_HOUR:    rd_byte = hour_q;
                ADDR_DATE:    rd_byte = date_q;
                ADDR_MONTH:   rd_byte = month_q;
                ADDR_DAY:     rd_byte = day_q;
                ADDR_YEAR:    rd_byte = year_q;
                ADDR_CTRL:    rd_byte = ctrl_q;
                ADDR_TRICKLE: rd_byte = trickle_q;
                default:      rd_byte = 8'h00;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write commit and timekeeping control
    // ------------------------------------------------------------------
    logic wr_en;
    logic wr_allowed;
    logic wr_commit;
    logic time_wr;
    logic tick_go;
    logic sec_roll;
    logic min_roll;
    logic hour_roll;

    assign wr_en      = (state_q == S_WCOMMIT);
    // Write protect blocks every target except the control register itself,
    // otherwise WP could never be cleared.
    assign wr_allowed = ~ctrl_q[7] | (~cmd_ram_q & (cmd_addr_q == ADDR_CTRL));
    assign wr_commit  = wr_en & wr_allowed;
    assign time_wr    = wr_commit & ~cmd_ram_q & (cmd_addr_q <= ADDR_HOUR);
    // A host write to the time registers wins over a coincident tick.
    assign tick_go    = tick_1hz & ~sec_q[7] & ~time_wr;
    assign sec_roll   = (sec_q[6:0] == 7'h59);
    assign min_roll   = (min_q[6:0] == 7'h59);
    assign hour_roll  = (hour_q[6:0] == 7'h23);

    // Plain BCD step: the low nibble counts up and rolls into the high
    // nibble after 9. Out-of-range host values are stepped without checking.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'h9) begin
            return {v[7:4] + 4'h1, 4'h0};
        end
        return {v[7:4], v[3:0] + 4'h1};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q     <= 8'h80;
            min_q     <= 8'h00;
            hour_q    <= 8'h00;
            date_q    <= 8'h00;
            month_q   <= 8'h00;
            day_q     <= 8'h00;
            year_q    <= 8'h00;
            ctrl_q    <= 8'h80;
            trickle_q <= 8'h00;
        end else begin
            if (tick_go) begin
                sec_q <= sec_roll ? {sec_q[7], 7'h00} : bcd_inc(sec_q);
                if (sec_roll) begin
                    min_q <= min_roll ? {min_q[7], 7'h00} : bcd_inc(min_q);
                    if (min_roll) begin
                        hour_q <= hour_roll ? {hour_q[7], 7'h00} : bcd_inc(hour_q);
                    end
                end
            end
            if (wr_commit && !cmd_ram_q) begin
                case (cmd_addr_q)
                    ADDR_SEC:     sec_q     <= shreg_q;
                    ADDR_MIN:     min_q     <= shreg_q;
                    ADDR_HOUR:    hour_q    <= shreg_q;
                    ADDR_DATE:    date_q    <= shreg_q;
                    ADDR_MONTH:   month_q   <= shreg_q;
                    ADDR_DAY:     day_q     <= shreg_q;
                    ADDR_YEAR:    year_q    <= shreg_q;
                    ADDR_CTRL:    ctrl_q    <= shreg_q;
                    ADDR_TRICKLE: trickle_q <= shreg_q;
                    default:      ;
                endcase
            end
        end
    end

    // NOTE: the RAM is built from flops and must come up as all zeros, so it
    // is cleared by the asynchronous reset; this rules out a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAM_BYTES; i++) begin
                ram[i] <= 8'h00;
            end
        end else if (wr_commit && cmd_ram_q && (int'(cmd_addr_q) < RAM_BYTES)) begin
            ram[cmd_addr_q[RAM_AW-1:0]] <= shreg_q;
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shreg_q    <= 8'h00;
            cmd_addr_q <= 5'd0;
            cmd_ram_q  <= 1'b0;
            io_out     <= 1'b0;
            io_oe      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_ram_q  <= cmd_ram_d;
            io_out     <= io_out_d;
            io_oe      <= io_oe_d;
            frame_done <= done_d;
            frame_err  <= err_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        cmd_addr_d = cmd_addr_q;
        cmd_ram_d  = cmd_ram_q;
        io_out_d   = io_out;
        io_oe_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        // A fully shifted write byte commits even if CE drops in that cycle.
        if (state_q == S_WCOMMIT) begin
            done_d = 1'b1;
        end

        if (!ce_s) begin
            state_d = S_IDLE;
            if (state_q inside {S_CMD, S_WDATA, S_RDATA}) begin
                err_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    bit_cnt_d = 3'd0;
                    state_d   = S_CMD;
                end
                S_CMD: begin
                    if (sclk_rise) begin
                        shreg_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (!shift_in[7]) begin
                                err_d   = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                cmd_addr_d = in_addr;
                                cmd_ram_d  = in_ram;
                                if (shift_in[0]) begin
                                    shreg_d = rd_byte;
                                    state_d = S_RDATA;
                                end else begin
                                    state_d = S_WDATA;
                                end
                            end
                        end
                    end
                end
                S_WDATA: begin
                    if (sclk_rise) begin
                        shreg_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_WCOMMIT;
                        end
                    end
                end
                S_WCOMMIT: begin
                    state_d = S_DONE;
                end
                S_RDATA: begin
                    io_oe_d = io_oe;
                    if (sclk_fall) begin
                        // The counter wraps back to 0 after the 8th bit, so
                        // "driving and count 0" marks the fall that ends the byte.
                        if (io_oe && (bit_cnt_q == 3'd0)) begin
                            io_oe_d = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            io_out_d  = shreg_q[0];
                            shreg_d   = {1'b0, shreg_q[7:1]};
                            io_oe_d   = 1'b1;
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign time_sec  = sec_q;
    assign time_min  = min_q;
    assign time_hour = hour_q;

endmodule

// File: tb/tb_ds1302_target.sv
// tb_ds1302_target
//   Self-checking bench for ds1302_target. Keeps a byte-level model of the
//   register set and RAM, drives whole CE frames bit by bit, and compares read
//   data, frame pulse counts and the running time registers against the model.

module tb_ds1302_target;

    localparam int SYNC_STAGES = 2;
    localparam int RAM_BYTES   = 31;
    localparam int HALF        = 6;   // clk cycles per SCLK phase

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b0;
    logic       sclk = 1'b0;
    logic       io_in = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       io_out;
    logic       io_oe;
    logic [7:0] time_sec;
    logic [7:0] time_min;
    logic [7:0] time_hour;
    logic       frame_done;
    logic       frame_err;

    always #5 clk = ~clk;

    ds1302_target #(
        .SYNC_STAGES (SYNC_STAGES),
        .RAM_BYTES   (RAM_BYTES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .sclk       (sclk),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_oe      (io_oe),
        .tick_1hz   (tick_1hz),
        .time_sec   (time_sec),
        .time_min   (time_min),
        .time_hour  (time_hour),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_clk [0:8];
    logic [7:0] m_ram [0:RAM_BYTES-1];

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] cmd);
        int a;
        a = int'(cmd[5:1]);
        if (cmd[6]) begin
            return (a < RAM_BYTES) ? m_ram[a] : 8'h00;
        end
        return (a <= 8) ? m_clk[a] : 8'h00;
    endfunction

    task automatic model_tick();
        int s, m, h;
        logic [7:0] hb;
        if (m_clk[0][7]) return;
        s = from_bcd({1'b0, m_clk[0][6:0]});
        m = from_bcd({1'b0, m_clk[1][6:0]});
        h = from_bcd({1'b0, m_clk[2][6:0]});
        if (s == 59) begin
            s = 0;
            if (m == 59) begin
                m = 0;
                h = (h == 23) ? 0 : h + 1;
            end else begin
                m = m + 1;
            end
        end else begin
            s = s + 1;
        end
        m_clk[0] = {m_clk[0][7], to_bcd(s)[6:0]};
        m_clk[1] = {m_clk[1][7], to_bcd(m)[6:0]};
        hb       = to_bcd(h);
        m_clk[2] = {m_clk[2][7], hb[6:0]};
    endtask

    task automatic model_write(input logic [7:0] cmd, input logic [7:0] data, output bit time_commit);
        int a;
        a = int'(cmd[5:1]);
        time_commit = 1'b0;
        if (m_clk[7][7] && !(!cmd[6] && a == 7)) return;
        if (cmd[6]) begin
            if (a < RAM_BYTES) m_ram[a] = data;
        end else if (a <= 8) begin
            m_clk[a] = data;
            time_commit = (a <= 2);
        end
    endtask

    // ---------------- monitor / per-cycle compare ----------------
    bit chk_en   = 1'b0;
    int done_cnt = 0;
    int err_cnt  = 0;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) err_cnt++;
        if (chk_en) begin
            check("idle_time", {8'h00, time_hour, time_min, time_sec},
                  {8'h00, m_clk[2], m_clk[1], m_clk[0]});
            check("idle_bus", {29'd0, io_oe, frame_done, frame_err}, 32'd0);
        end
    end

    // ---------------- bus driver ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_tick();
        chk_en   = 1'b0;
        tick_1hz = 1'b1;
        wait_clk(1);
        tick_1hz = 1'b0;
        model_tick();
        wait_clk(1);
        chk_en = 1'b1;
    endtask

    // One CE frame. nbits < 8 on a write drops CE after that many data bits.
    // tick_at_commit raises tick_1hz in the clk where a write commits.
    task automatic xfer(input logic [7:0] cmd, input logic [7:0] wdata, input int nbits,
                        input bit tick_at_commit, output logic [7:0] rdata);
        int   d0, e0, exp_done, exp_err;
        logic [7:0] exp_rd;
        bit   tcommit;
        chk_en   = 1'b0;
        d0       = done_cnt;
        e0       = err_cnt;
        exp_rd   = model_read(cmd);
        rdata    = 8'h00;
        exp_done = 0;
        exp_err  = 0;
        ce = 1'b1;
        wait_clk(HALF);
        for (int i = 0; i < 8; i++) begin
            io_in = cmd[i];
            wait_clk(HALF);
            check("cmd_phase_oe", 32'(io_oe), 32'd0);
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        if (!cmd[7]) begin
            for (int i = 0; i < 8; i++) begin
                io_in = 1'($urandom_range(0, 1));
                wait_clk(HALF);
                check("bad_cmd_oe", 32'(io_oe), 32'd0);
                sclk = 1'b1;
                wait_clk(HALF);
                sclk = 1'b0;
            end
            exp_err = 1;
        end else if (cmd[0]) begin
            for (int i = 0; i < 8; i++) begin
                wait_clk(HALF);
                check("read_oe", 32'(io_oe), 32'd1);
                rdata[i] = io_out;
                sclk = 1'b1;
                wait_clk(HALF);
                sclk = 1'b0;
            end
            wait_clk(HALF);
            check("read_end_oe", 32'(io_oe), 32'd0);
            check("read_data", 32'(rdata), 32'(exp_rd));
            exp_done = 1;
        end else begin
            for (int i = 0; i < nbits; i++) begin
                io_in = wdata[i];
                wait_clk(HALF);
                sclk = 1'b1;
                if (tick_at_commit && i == 7) begin
                    wait_clk(SYNC_STAGES + 1);
                    tick_1hz = 1'b1;
                    wait_clk(1);
                    tick_1hz = 1'b0;
                    wait_clk(HALF - SYNC_STAGES - 2);
                end else begin
                    wait_clk(HALF);
                end
                sclk = 1'b0;
            end
            wait_clk(HALF);
            if (nbits < 8) begin
                exp_err = 1;
            end else begin
                exp_done = 1;
                model_write(cmd, wdata, tcommit);
                if (tick_at_commit && !tcommit) model_tick();
            end
        end
        ce = 1'b0;
        wait_clk(SYNC_STAGES + 3);
        check("ce_low_oe", 32'(io_oe), 32'd0);
        check("frame_done_count", 32'(done_cnt - d0), 32'(exp_done));
        check("frame_err_count", 32'(err_cnt - e0), 32'(exp_err));
        chk_en = 1'b1;
    endtask

    task automatic wr(input logic [7:0] cmd, input logic [7:0] data);
        logic [7:0] unused_rd;
        xfer(cmd, data, 8, 1'b0, unused_rd);
    endtask

    task automatic rd(input logic [7:0] cmd, output logic [7:0] data);
        xfer(cmd, 8'h00, 8, 1'b0, data);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] r;
        logic [7:0] cmd;
        logic [7:0] data;
        logic [4:0] a;
        int         kind;
        int         nb;
        bit         is_ram;

        for (int i = 0; i < 9; i++) m_clk[i] = 8'h00;
        for (int i = 0; i < RAM_BYTES; i++) m_ram[i] = 8'h00;
        m_clk[0] = 8'h80;
        m_clk[7] = 8'h80;

        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2);
        check("reset_sec", 32'(time_sec), 32'h80);
        check("reset_min_hour", {16'd0, time_hour, time_min}, 32'h0);
        check("reset_outputs", {28'd0, io_out, io_oe, frame_done, frame_err}, 32'h0);
        chk_en = 1'b1;
        wait_clk(4);

        // Read seconds straight after reset.
        rd(8'h81, r);
        check("lit_read_sec_reset", 32'(r), 32'h80);

        // Clear WP, set hour, read it back.
        wr(8'h8E, 8'h00);
        wr(8'h84, 8'h23);
        rd(8'h85, r);
        check("lit_read_hour", 32'(r), 32'h23);
        check("lit_time_hour", 32'(time_hour), 32'h23);

        // Write protect blocks RAM writes but still completes the frame.
        wr(8'h8E, 8'h80);
        wr(8'hC0, 8'h5A);
        rd(8'hC1, r);
        check("lit_wp_blocked", 32'(r), 32'h00);
        wr(8'h8E, 8'h00);
        wr(8'hC0, 8'h5A);
        rd(8'hC1, r);
        check("lit_wp_cleared", 32'(r), 32'h5A);

        // Full rollover 23:59:59 -> 00:00:00, then halted clock ignores ticks.
        wr(8'h80, 8'h59);
        wr(8'h82, 8'h59);
        wr(8'h84, 8'h23);
        do_tick();
        check("lit_rollover", {8'h00, time_hour, time_min, time_sec}, 32'h0);
        wr(8'h80, 8'hD9);
        do_tick();
        check("lit_halted", {8'h00, time_hour, time_min, time_sec}, 32'h0000D9);

        // Tick in the commit clk of a seconds write: the write wins.
        xfer(8'h80, 8'h10, 8, 1'b1, r);
        check("lit_write_wins", 32'(time_sec), 32'h10);
        do_tick();
        check("lit_tick_after", 32'(time_sec), 32'h11);

        // CE dropped after 4 data bits: RAM1 keeps its old value.
        wr(8'hC2, 8'h33);
        xfer(8'hC2, 8'hCC, 4, 1'b0, r);
        rd(8'hC3, r);
        check("lit_partial_discard", 32'(r), 32'h33);

        // Invalid command, then a valid read.
        xfer(8'h01, 8'h00, 8, 1'b0, r);
        rd(8'h81, r);

        // Address boundaries.
        rd(8'h93, r);
        check("lit_clk_addr9", 32'(r), 32'h00);
        wr(8'hFC, 8'hA7);
        rd(8'hFD, r);
        check("lit_ram_last", 32'(r), 32'hA7);
        wr(8'hFE, 8'h77);
        rd(8'hFF, r);
        check("lit_ram_oob", 32'(r), 32'h00);
        wr(8'hBE, 8'h77);
        rd(8'hBF, r);
        check("lit_clk_addr31", 32'(r), 32'h00);

        // Randomized traffic against the model.
        for (int n = 0; n < 120; n++) begin
            kind   = $urandom_range(0, 9);
            is_ram = 1'($urandom_range(0, 1));
            a      = is_ram ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 11));
            nb     = 8;
            data   = 8'($urandom);
            if (!is_ram) begin
                case (a)
                    5'd0: data = {1'($urandom_range(0, 1)), to_bcd($urandom_range(0, 59))[6:0]};
                    5'd1: data = to_bcd($urandom_range(0, 59));
                    5'd2: data = to_bcd($urandom_range(0, 23));
                    default: ;
                endcase
            end
            if (kind == 0) begin
                cmd = {1'b0, 7'($urandom)};
            end else if (kind <= 4) begin
                cmd = {1'b1, is_ram, a, 1'b1};
            end else begin
                cmd = {1'b1, is_ram, a, 1'b0};
                if (kind == 9) nb = $urandom_range(0, 7);
            end
            xfer(cmd, data, nb, 1'b0, r);
            repeat ($urandom_range(0, 3)) do_tick();
            wait_clk($urandom_range(1, 5));
        end

        // Let the clock run a little with CH cleared.
        wr(8'h80, 8'h58);
        repeat (3) do_tick();
        wait_clk(10);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
